// File: rtl/pll_drp_ctrl_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces for pll_drp_ctrl.
//
// pll_req_if : masked register-write request stream (sequencer -> controller)
//   valid/ready : handshake, a beat transfers when both are high
//   addr        : DRP register address
//   mask        : 1 = keep the old register bit, 0 = take the bit from data
//   data        : new bit values
//   last        : final request of a reconfiguration sequence
//
// pll_drp_if : DRP port plus reset/lock of the PLL (controller -> PLL)
//   daddr/den/dwe/di : DRP address, enable, write enable, write data
//   dout/drdy        : DRP read data and ready (DO/DRDY on the primitive)
//   pll_rst          : PLL RST input, active-high
//   locked           : PLL LOCKED output
// -----------------------------------------------------------------------------
interface pll_req_if;
  logic        valid;
  logic        ready;
  logic [6:0]  addr;
  logic [15:0] mask;
  logic [15:0] data;
  logic        last;

  modport master (output valid, addr, mask, data, last, input ready);
  modport slave  (input valid, addr, mask, data, last, output ready);
endinterface

interface pll_drp_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  logic        pll_rst;
  logic        locked;

  modport master (output daddr, den, dwe, di, pll_rst, input dout, drdy, locked);
  modport slave  (input daddr, den, dwe, di, pll_rst, output dout, drdy, locked);
endinterface

// File: rtl/pll_drp_ctrl.sv
// -----------------------------------------------------------------------------
// pll_drp_ctrl : DRP initiator that reconfigures a PLL at run time.
//
// Each accepted request performs one read-modify-write of a DRP register:
// new = (old & mask) | (data & ~mask). The PLL is held in reset from the
// first accept until the write of the request marked last completes, then
// released; the controller waits for LOCKED to go low and come back high.
//
// Ports:
//   dclk_i  : DRP clock, the only clock
//   rst_ni  : asynchronous active-low reset
//   req     : request stream (pll_req_if.slave)
//   drp     : DRP port, PLL reset and LOCKED (pll_drp_if.master)
//   busy_o  : high whenever the controller is not idle
//   done_o  : one-cycle pulse when LOCKED is regained after the last request
//   error_o : sticky timeout flag, cleared by the next request accepted in idle
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pll_drp_ctrl #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic      dclk_i,
  input  logic      rst_ni,
  pll_req_if.slave  req,
  pll_drp_if.master drp,
  output logic      busy_o,
  output logic      done_o,
  output logic      error_o
);

  localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_WRITE,
    S_WAIT_WR,
    S_HOLD,
    S_WAIT_LOCK
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    addr_q, addr_d;
  logic [15:0]   mask_q, mask_d;
  logic [15:0]   data_q, data_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          seen_low_q, seen_low_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          den_q, den_d;
  logic          dwe_q, dwe_d;
  logic          pll_rst_q, pll_rst_d;
  logic [15:0]   di_q, di_d;

  logic          accept;
  logic [TW-1:0] timer_inc;
  logic          drdy_expired;
  logic          lock_expired;
  logic          in_wait;

  assign accept    = req.valid & ready_q;
  assign timer_inc = timer_q + TW'(1);
  // timer_q counts cycles already spent in the current wait state, so the
  // cycle in which timer_inc hits the limit is the last one allowed.
  assign drdy_expired = (timer_inc == TW'(DRDY_TIMEOUT));
  assign lock_expired = (timer_inc == TW'(LOCK_TIMEOUT));
  assign in_wait = (state_q == S_WAIT_RD) || (state_q == S_WAIT_WR) ||
                   (state_q == S_WAIT_LOCK);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    data_d     = data_q;
    last_d     = last_q;
    seen_low_d = seen_low_q;
    error_d    = error_q;
    pll_rst_d  = pll_rst_q;
    di_d       = di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    done_d     = 1'b0;
    timer_d    = '0;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          addr_d    = req.addr;
          mask_d    = req.mask;
          data_d    = req.data;
          last_d    = req.last;
          pll_rst_d = 1'b1;
          error_d   = 1'b0;
          den_d     = 1'b1;   // READ cycle drives DEN straight from the flop
          state_d   = S_READ;
        end
      end

      S_READ: state_d = S_WAIT_RD;

      S_WAIT_RD: begin
        if (drp.drdy) begin
          // Merge is computed from DO as it arrives so DI is ready in WRITE.
          di_d    = (drp.dout & mask_q) | (data_q & ~mask_q);
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          state_d = S_WRITE;
        end else if (drdy_expired) begin
          error_d   = 1'b1;
          pll_rst_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_WRITE: state_d = S_WAIT_WR;

      S_WAIT_WR: begin
        if (drp.drdy) begin
          if (last_q) begin
            pll_rst_d  = 1'b0;
            seen_low_d = 1'b0;
            state_d    = S_WAIT_LOCK;
          end else begin
            state_d = S_HOLD;
          end
        end else if (drdy_expired) begin
          error_d   = 1'b1;
          pll_rst_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_WAIT_LOCK: begin
        // LOCKED may still be high from before the reconfiguration; only a
        // high seen after at least one low counts as a fresh lock.
        if (drp.locked && seen_low_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (!drp.locked) seen_low_d = 1'b1;
          if (lock_expired) begin
            error_d   = 1'b1;
            pll_rst_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (in_wait && (state_d == state_q)) timer_d = timer_inc;

    ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge dclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mask_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      timer_q    <= '0;
      seen_low_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      pll_rst_q  <= 1'b0;
      di_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      seen_low_q <= seen_low_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      pll_rst_q  <= pll_rst_d;
      di_q       <= di_d;
    end
  end

  assign req.ready   = ready_q;
  assign drp.daddr   = addr_q;
  assign drp.den     = den_q;
  assign drp.dwe     = dwe_q;
  assign drp.di      = di_q;
  assign drp.pll_rst = pll_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pll_drp_ctrl. A behavioural PLL (register array, DRDY latency,
// LOCKED behaviour) answers the DRP port; expected register contents follow
// the masked-write rule applied in request order.
// -----------------------------------------------------------------------------
module tb_pll_drp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_req_if req_bus ();
  pll_drp_if drp_bus ();
  logic busy, done, error;

  pll_drp_ctrl #(.DRDY_TIMEOUT(64), .LOCK_TIMEOUT(4096)) dut (
    .dclk_i(clk), .rst_ni(rst_n), .req(req_bus), .drp(drp_bus),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // PLL model controls (written by tests only)
  int rd_lat = 3, wr_lat = 2, lock_lat = 100, lock_mode = 0;
  bit no_drdy = 1'b0;
  bit lock_manual = 1'b1;
  int spur_req = 0;
  // PLL model observations (written by the model only)
  logic [15:0] pll_mem [128];
  int den_total = 0, den_pairs = 0, done_total = 0, bad_ready = 0;
  logic [15:0] exp_mem [128];

  // Behavioural PLL: answers DEN after a set latency, stores writes,
  // drops LOCKED while in reset and relocks lock_lat cycles after release.
  initial begin
    int cnt, lcnt, spur_seen;
    logic [6:0] rd_addr;
    bit outstanding, prev_den;
    cnt = 0; lcnt = 0; spur_seen = 0; rd_addr = '0; outstanding = 0; prev_den = 0;
    for (int i = 0; i < 128; i++) pll_mem[i] = 16'($urandom);
    pll_mem[8] = 16'hA5A5;
    drp_bus.drdy = 1'b0; drp_bus.dout = '0; drp_bus.locked = 1'b1;
    forever begin
      @(negedge clk);
      if (drp_bus.den) begin
        den_total++;
        if (prev_den) den_pairs++;
        if (drp_bus.dwe) pll_mem[drp_bus.daddr] = drp_bus.di;
        rd_addr = drp_bus.daddr;
        if (!no_drdy) begin
          cnt = drp_bus.dwe ? wr_lat : rd_lat;
          outstanding = 1;
        end
      end
      if ((drp_bus.den || outstanding) && req_bus.ready) bad_ready++;
      if (done) done_total++;
      prev_den = drp_bus.den;
      drp_bus.drdy = 1'b0;
      if (!drp_bus.den && cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_bus.drdy = 1'b1;
          drp_bus.dout = pll_mem[rd_addr];
          outstanding = 0;
        end
      end
      if (spur_req != spur_seen) begin
        drp_bus.drdy = 1'b1;
        spur_seen = spur_req;
      end
      case (lock_mode)
        0: begin
          if (drp_bus.pll_rst) begin
            drp_bus.locked = 1'b0; lcnt = lock_lat;
          end else if (lcnt > 0) begin
            lcnt--;
            if (lcnt == 0) drp_bus.locked = 1'b1;
          end
        end
        1: if (drp_bus.pll_rst) drp_bus.locked = 1'b0;
        default: drp_bus.locked = lock_manual;
      endcase
    end
  end

  function automatic logic [15:0] rmw(input logic [15:0] old, input logic [15:0] m,
                                      input logic [15:0] d);
    return (old & m) | (d & ~m);
  endfunction

  // Presents one request and returns on the negedge after it was accepted.
  task automatic send_req(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                          input bit l, output bit ok);
    int k;
    req_bus.addr = a; req_bus.mask = m; req_bus.data = d; req_bus.last = l;
    req_bus.valid = 1'b1;
    k = 0;
    while (!req_bus.ready && k < 300) begin @(negedge clk); k++; end
    ok = req_bus.ready;
    if (ok) @(negedge clk);
    req_bus.valid = 1'b0;
    $display("req addr=%h mask=%h data=%h last=%0d accepted=%0d", a, m, d, l, ok);
  endtask

  task automatic wait_write_den(output int k);
    k = 0;
    while (!(drp_bus.den && drp_bus.dwe) && k < 200) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_bus.ready, busy, done, error, drp_bus.den, drp_bus.dwe, drp_bus.di,
         drp_bus.daddr, drp_bus.pll_rst} !== 30'd0) begin
      n_bad++; $display("FAIL reset_outputs: got nonzero ready=%b busy=%b den=%b di=%h daddr=%h pll_rst=%b want all 0",
                        req_bus.ready, busy, drp_bus.den, drp_bus.di, drp_bus.daddr, drp_bus.pll_rst);
    end
    for (int i = 0; i < 128; i++) exp_mem[i] = pll_mem[i];
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_bus.ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL reset_release: ready/busy got %b want 10", {req_bus.ready, busy});
    end
  endtask

  task automatic test_single;
    bit ok; int k; int d0, n0;
    rd_lat = 3; wr_lat = 2; lock_mode = 0; lock_lat = 100;
    d0 = done_total; n0 = den_total;
    exp_mem[8] = rmw(exp_mem[8], 16'hFF00, 16'h1234);
    send_req(7'h08, 16'hFF00, 16'h1234, 1'b1, ok);
    n_cmp++;
    if ({ok, drp_bus.den, drp_bus.dwe, drp_bus.daddr, drp_bus.pll_rst} !== {3'b110, 7'h08, 1'b1}) begin
      n_bad++; $display("FAIL single_read: ok/den/dwe/daddr/pll_rst got %b%b%b %h %b want 110 08 1",
                        ok, drp_bus.den, drp_bus.dwe, drp_bus.daddr, drp_bus.pll_rst);
    end
    wait_write_den(k);
    n_cmp++;
    if (k !== 4 || drp_bus.di !== 16'hA534 || drp_bus.daddr !== 7'h08) begin
      n_bad++; $display("FAIL single_write: delay=%0d di=%h daddr=%h want 4 a534 08", k, drp_bus.di, drp_bus.daddr);
    end
    k = 0;
    while (drp_bus.pll_rst && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (k !== 3) begin n_bad++; $display("FAIL single_rst_release: delay got %0d want 3", k); end
    k = 0;
    while (!done && k < 400) begin @(negedge clk); k++; end
    n_cmp++;
    if (k !== 100 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_done: delay=%0d busy=%b want 100 0", k, busy);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_total - d0 !== 1 || den_total - n0 !== 2 || pll_mem[8] !== 16'hA534) begin
      n_bad++; $display("FAIL single_totals: done=%0d den=%0d reg=%h want 1 2 a534",
                        done_total - d0, den_total - n0, pll_mem[8]);
    end
  endtask

  task automatic test_three;
    bit ok; int k; int d0, n0, p0, r0;
    logic [6:0] addrs [3];
    logic [15:0] m, d, e;
    addrs[0] = 7'h08; addrs[1] = 7'h09; addrs[2] = 7'h14;
    rd_lat = $urandom_range(1, 6); wr_lat = $urandom_range(1, 6); lock_lat = $urandom_range(5, 40);
    d0 = done_total; n0 = den_total; p0 = den_pairs; r0 = bad_ready;
    for (int i = 0; i < 3; i++) begin
      m = 16'($urandom); d = 16'($urandom);
      e = rmw(exp_mem[addrs[i]], m, d);
      exp_mem[addrs[i]] = e;
      send_req(addrs[i], m, d, i == 2, ok);
      n_cmp++;
      if ({ok, drp_bus.den, drp_bus.daddr, drp_bus.pll_rst} !== {2'b11, addrs[i], 1'b1}) begin
        n_bad++; $display("FAIL three_read%0d: ok/den/daddr/pll_rst got %b%b %h %b want 11 %h 1",
                          i, ok, drp_bus.den, drp_bus.daddr, drp_bus.pll_rst, addrs[i]);
      end
      wait_write_den(k);
      n_cmp++;
      if (drp_bus.di !== e || drp_bus.pll_rst !== 1'b1) begin
        n_bad++; $display("FAIL three_write%0d: di=%h pll_rst=%b want %h 1", i, drp_bus.di, drp_bus.pll_rst, e);
      end
    end
    k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (den_total - n0 !== 6 || den_pairs - p0 !== 0 || bad_ready - r0 !== 0 || done_total - d0 !== 1) begin
      n_bad++; $display("FAIL three_totals: den=%0d pairs=%0d bad_ready=%0d done=%0d want 6 0 0 1",
                        den_total - n0, den_pairs - p0, bad_ready - r0, done_total - d0);
    end
  endtask

  task automatic test_early_valid;
    bit ok; int k; int d0, r0;
    logic [15:0] ma, da, mb, db, ea, eb;
    rd_lat = 5; wr_lat = 3; lock_lat = 30;
    spur_req++;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy, drp_bus.den, req_bus.ready} !== 3'b001) begin
      n_bad++; $display("FAIL spurious_drdy: busy/den/ready got %b want 001", {busy, drp_bus.den, req_bus.ready});
    end
    d0 = done_total; r0 = bad_ready;
    ma = 16'($urandom); da = 16'($urandom); mb = 16'($urandom); db = 16'($urandom);
    ea = rmw(exp_mem[7'h20], ma, da); exp_mem[7'h20] = ea;
    eb = rmw(exp_mem[7'h21], mb, db); exp_mem[7'h21] = eb;
    send_req(7'h20, ma, da, 1'b0, ok);
    @(negedge clk);
    send_req(7'h21, mb, db, 1'b1, ok);
    n_cmp++;
    if ({ok, drp_bus.den, drp_bus.dwe, drp_bus.daddr} !== {3'b110, 7'h21} || pll_mem[7'h20] !== ea) begin
      n_bad++; $display("FAIL early_accept: ok/den/dwe=%b%b%b daddr=%h regA=%h want 110 21 %h",
                        ok, drp_bus.den, drp_bus.dwe, drp_bus.daddr, pll_mem[7'h20], ea);
    end
    wait_write_den(k);
    n_cmp++;
    if (drp_bus.di !== eb) begin n_bad++; $display("FAIL early_payload: di got %h want %h", drp_bus.di, eb); end
    k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bad_ready - r0 !== 0 || done_total - d0 !== 1) begin
      n_bad++; $display("FAIL early_totals: bad_ready=%0d done=%0d want 0 1", bad_ready - r0, done_total - d0);
    end
  endtask

  task automatic test_drdy_timeout;
    bit ok; int k; int d0, n0;
    logic [15:0] m, d;
    lock_lat = 20; rd_lat = 2; wr_lat = 2;
    d0 = done_total; n0 = den_total;
    no_drdy = 1'b1;
    send_req(7'h30, 16'h0F0F, 16'h1111, 1'b1, ok);
    k = 0;
    while (!error && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (k !== 65 || {drp_bus.pll_rst, busy, req_bus.ready} !== 3'b001) begin
      n_bad++; $display("FAIL drdy_timeout: delay=%0d pll_rst/busy/ready=%b want 65 001",
                        k, {drp_bus.pll_rst, busy, req_bus.ready});
    end
    no_drdy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (den_total - n0 !== 1 || done_total - d0 !== 0 || error !== 1'b1) begin
      n_bad++; $display("FAIL drdy_timeout_totals: den=%0d done=%0d error=%b want 1 0 1",
                        den_total - n0, done_total - d0, error);
    end
    m = 16'($urandom); d = 16'($urandom);
    exp_mem[7'h31] = rmw(exp_mem[7'h31], m, d);
    send_req(7'h31, m, d, 1'b1, ok);
    n_cmp++;
    if (error !== 1'b0) begin n_bad++; $display("FAIL error_clear: error got %b want 0", error); end
    k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL after_error_done: done got 0 want 1"); end
  endtask

  task automatic test_lock;
    bit ok, seen; int k; int d0;
    logic [15:0] m, d;
    rd_lat = 2; wr_lat = 2;
    lock_mode = 1;
    d0 = done_total;
    m = 16'($urandom); d = 16'($urandom);
    exp_mem[7'h40] = rmw(exp_mem[7'h40], m, d);
    send_req(7'h40, m, d, 1'b1, ok);
    k = 0;
    while (drp_bus.pll_rst && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (!error && k < 5000) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (k !== 4096 || done_total - d0 !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL lock_timeout: delay=%0d done=%0d busy=%b want 4096 0 0", k, done_total - d0, busy);
    end
    lock_mode = 2; lock_manual = 1'b1;
    m = 16'($urandom); d = 16'($urandom);
    exp_mem[7'h41] = rmw(exp_mem[7'h41], m, d);
    send_req(7'h41, m, d, 1'b1, ok);
    k = 0;
    while (drp_bus.pll_rst && k < 50) begin @(negedge clk); k++; end
    seen = 0;
    repeat (50) begin @(negedge clk); if (done) seen = 1; end
    n_cmp++;
    if (seen !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL lock_held_high: done_seen=%b busy=%b want 0 1", seen, busy);
    end
    lock_manual = 1'b0;
    repeat (3) @(negedge clk);
    lock_manual = 1'b1;
    k = 0;
    while (!done && k < 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL lock_relock: done got %b want 1", done); end
    lock_mode = 0;
  endtask

  task automatic test_reset_midop;
    bit ok; int k;
    logic [15:0] m, d;
    rd_lat = 2; wr_lat = 20; lock_lat = 20;
    m = 16'($urandom); d = 16'($urandom);
    exp_mem[7'h50] = rmw(exp_mem[7'h50], m, d);
    send_req(7'h50, m, d, 1'b0, ok);
    wait_write_den(k);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({drp_bus.pll_rst, busy} !== 2'b11) begin
      n_bad++; $display("FAIL midop_pre: pll_rst/busy got %b want 11", {drp_bus.pll_rst, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({drp_bus.pll_rst, drp_bus.den, busy, req_bus.ready} !== 4'b0000) begin
      n_bad++; $display("FAIL midop_async: pll_rst/den/busy/ready got %b want 0000",
                        {drp_bus.pll_rst, drp_bus.den, busy, req_bus.ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_bus.ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL midop_release: ready/busy got %b want 10", {req_bus.ready, busy});
    end
    repeat (25) @(negedge clk);
    n_cmp++;
    if ({busy, drp_bus.den} !== 2'b00) begin
      n_bad++; $display("FAIL midop_stale_drdy: busy/den got %b want 00", {busy, drp_bus.den});
    end
    wr_lat = 2;
  endtask

  task automatic test_random;
    bit ok; int k, len, bad_regs;
    logic [6:0] a;
    logic [15:0] m, d, e;
    for (int s = 0; s < 3; s++) begin
      len = $urandom_range(1, 3);
      rd_lat = $urandom_range(1, 8); wr_lat = $urandom_range(1, 8); lock_lat = $urandom_range(2, 30);
      for (int i = 0; i < len; i++) begin
        a = 7'($urandom_range(0, 127)); m = 16'($urandom); d = 16'($urandom);
        e = rmw(exp_mem[a], m, d);
        exp_mem[a] = e;
        send_req(a, m, d, i == len - 1, ok);
        n_cmp++;
        if ({ok, drp_bus.den, drp_bus.dwe, drp_bus.daddr} !== {3'b110, a}) begin
          n_bad++; $display("FAIL rand_read s%0d r%0d: ok/den/dwe=%b%b%b daddr=%h want 110 %h",
                            s, i, ok, drp_bus.den, drp_bus.dwe, drp_bus.daddr, a);
        end
        wait_write_den(k);
        n_cmp++;
        if (k !== rd_lat + 1 || drp_bus.di !== e) begin
          n_bad++; $display("FAIL rand_write s%0d r%0d: delay=%0d di=%h want %0d %h", s, i, k, drp_bus.di, rd_lat + 1, e);
        end
      end
      k = 0;
      while (!done && k < 200) begin @(negedge clk); k++; end
      n_cmp++;
      if (!done) begin n_bad++; $display("FAIL rand_done s%0d: done got 0 want 1", s); end
      @(negedge clk);
    end
    bad_regs = 0;
    for (int i = 0; i < 128; i++) if (pll_mem[i] !== exp_mem[i]) bad_regs++;
    n_cmp++;
    if (bad_regs !== 0) begin n_bad++; $display("FAIL final_regs: wrong registers got %0d want 0", bad_regs); end
  endtask

  initial begin
    req_bus.valid = 1'b0; req_bus.addr = '0; req_bus.mask = '0;
    req_bus.data = '0; req_bus.last = 1'b0;
    test_reset;
    test_single;
    test_three;
    test_early_valid;
    test_drdy_timeout;
    test_lock;
    test_reset_midop;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
